ovc_status_table: RTL
=====================

Name: ovc_status_table

Overview:
- Registered status table for all output VCs (OVCs) of a router: one busy/allocated flag and one downstream credit counter per OVC.
- Updated by the VC allocator (alloc), the switch traversal stage (flit sent, tail release) and downstream credit returns.
- A port/VC-indexed read path gives the selected OVC's status one cycle later. Flattened all-OVC vectors feed the allocators.
- Successor to the combinational per-bit status select: it holds the state, counts credits, and supports multiple status fields.

Parameters:
- PORT_NUM, 4, number of output ports.
- VC_NUM_PER_PORT, 4, OVCs per port.
- CREDIT_DEPTH, 4, downstream buffer depth per VC (credit reset value), >=1.
- PORT_BCD_WIDTH, log2(PORT_NUM), derived.
- VC_BCD_WIDTH, log2(VC_NUM_PER_PORT), derived.
- CREDIT_WIDTH, log2(CREDIT_DEPTH+1), derived.
- OVC_NUM, PORT_NUM*VC_NUM_PER_PORT, derived.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_en  in  1  allocate the OVC at alloc_port_bcd/alloc_vc_bcd.
- alloc_port_bcd  in  PORT_BCD_WIDTH; alloc_vc_bcd  in  VC_BCD_WIDTH.
- sent_en  in  1  one flit sent on the OVC at sent_port_bcd/sent_vc_bcd; consumes one credit.
- sent_tail  in  1  qualifies sent_en: the flit is a tail; releases that OVC.
- sent_port_bcd  in  PORT_BCD_WIDTH; sent_vc_bcd  in  VC_BCD_WIDTH.
- credit_in  in  OVC_NUM  one bit per OVC, index port*VC_NUM_PER_PORT+vc; any number may be set per cycle.
- rd_port_bcd  in  PORT_BCD_WIDTH; rd_vc_bcd  in  VC_BCD_WIDTH  read select.
- rd_busy  out  1  registered busy flag of the selected OVC.
- rd_credit  out  CREDIT_WIDTH  registered credit count of the selected OVC.
- rd_no_credit  out  1  registered; high when the selected OVC's credit count is 0.
- ovc_busy_all  out  OVC_NUM  busy flags, combinational from state.
- ovc_avail_all  out  OVC_NUM  per OVC: not busy and credit>0.
- err_flags  out  3  sticky errors: [0] alloc of a busy OVC, [1] sent with credit 0, [2] credit overflow.

Behaviour:
- Reset, asynchronous and active-high: all busy=0, all credit=CREDIT_DEPTH, rd_busy=0, rd_credit=0, rd_no_credit=0, err_flags=0.
- Busy flag update, per OVC, per clock:
  - Tail release is applied first, then alloc.
  - Release and alloc of the same OVC in the same cycle: busy ends at 1.
  - Alloc of an OVC that is busy and not being released: ignored; sets err[0].
  - Release of an OVC that is not busy: harmless, busy stays 0.
- Credit update, per OVC, per clock:
  - Next credit = credit - (sent on this OVC) + credit_in bit.
  - Sent and credit return on the same OVC in the same cycle: net 0, allowed even when credit is 0 or CREDIT_DEPTH.
  - Sent with credit 0 and no simultaneous return: decrement suppressed; sets err[1].
  - Return with credit at CREDIT_DEPTH and no simultaneous sent: saturates; sets err[2].
- sent_en on an OVC that is not busy: the credit is still consumed; no error.
- Read path:
  - 1-cycle latency; rd_* sample the state after this cycle's updates, i.e. the post-update value for the select presented in cycle N.
  - Indices >= PORT_NUM or >= VC_NUM_PER_PORT, for non-power-of-2 counts: rd_* = 0 next cycle.
- Flattened outputs reflect current registered state, so they are valid 0 cycles after the clock edge.
- Out-of-range alloc/sent indices: no state change.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight updates are lost.

Optional Feature:
- OVC_STATUS_ERR_EN defined: err_flags registers and detection logic are present. Bits are sticky until reset.
- Not defined: err_flags tied to 3'b000 and no detection logic is synthesised. Functional behaviour (suppression, saturation, ignore) is identical in both builds.

Decomposition:
- The shared define.v include holds the log2 function macro used for derived widths, and the OVC flat-index convention (port*VC_NUM_PER_PORT+vc).
- One natural sub-module: ovc_credit_cnt. It is generated OVC_NUM times and contains one credit counter with its sent/return/saturate logic and per-OVC error pulses.
- The busy flags, read mux and error OR-reduction stay at the top level.

Test Plan:
- Reset, then read port 2 / vc 1 -> after 1 cycle rd_busy=0, rd_credit=4, rd_no_credit=0; ovc_avail_all = all 1s.
- alloc p1v3, then 4 sent_en on p1v3 with no credit_in -> credit goes 4,3,2,1,0; rd_no_credit=1; ovc_avail_all bit 7 = 0.
- At credit 0: sent_en + credit_in[7] in the same cycle -> credit stays 0, err[1] stays 0. sent_en alone -> credit stays 0, err[1]=1 (ERR_EN build only).
- sent_tail on p0v0 while alloc_en p0v0 in the same cycle -> busy=1. A second alloc p0v0 next cycle -> err[0]=1, busy=1.
- credit_in all 1s at reset state -> all credits stay 4, err[2]=1; without OVC_STATUS_ERR_EN, err_flags=0.
- Assert reset mid-stream (credit p3v2 = 1, busy) -> same edge: credit=4, busy=0, rd_* =0.

Source files
------------

// File: rtl/ovc_status_table_pkg.sv
// Shared types and helpers for the OVC status table: index widths, the
// port*VC_NUM_PER_PORT+vc flat-index convention and the error-flag layout.
package ovc_status_table_pkg;

  // Bit 0 is alloc_busy, bit 1 is no_credit, bit 2 is credit_ovf (packed MSB first).
  typedef struct packed {
    logic credit_ovf;
    logic no_credit;
    logic alloc_busy;
  } err_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int flat_idx(input int port, input int vc, input int vc_num);
    return port * vc_num + vc;
  endfunction

endpackage

// File: rtl/ovc_credit_cnt.sv
// One downstream credit counter: decrement on sent, increment on return,
// saturating at 0 and CREDIT_DEPTH. Error pulses exist only with OVC_STATUS_ERR_EN.
module ovc_credit_cnt #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sent_i,
  input  logic                    ret_i,
  output logic [CREDIT_WIDTH-1:0] credit_o,
  output logic [CREDIT_WIDTH-1:0] credit_nxt_o
`ifdef OVC_STATUS_ERR_EN
  ,
  output logic                    underflow_o,
  output logic                    overflow_o
`endif
);

  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(CREDIT_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] ONE  = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    empty, full;

  assign empty = (credit_q == '0);
  assign full  = (credit_q == FULL);

  // Simultaneous sent and return cancel, so neither bound applies.
  always_comb begin
    credit_d = credit_q;
    if (sent_i && !ret_i && !empty) begin
      credit_d = credit_q - ONE;
    end else if (ret_i && !sent_i && !full) begin
      credit_d = credit_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q <= FULL;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o     = credit_q;
  assign credit_nxt_o = credit_d;

`ifdef OVC_STATUS_ERR_EN
  assign underflow_o = sent_i && !ret_i && empty;
  assign overflow_o  = ret_i && !sent_i && full;
`endif

endmodule

// File: rtl/ovc_status_table.sv
// Registered busy/credit status for every output VC with a 1-cycle read port.
// Build with OVC_STATUS_ERR_EN to get sticky err_flags; otherwise they read 0.
module ovc_status_table
  import ovc_status_table_pkg::*;
#(
  parameter int  PORT_NUM        = 4,
  parameter int  VC_NUM_PER_PORT = 4,
  parameter int  CREDIT_DEPTH    = 4,
  localparam int PORT_BCD_WIDTH  = idx_width(PORT_NUM),
  localparam int VC_BCD_WIDTH    = idx_width(VC_NUM_PER_PORT),
  localparam int CREDIT_WIDTH    = cnt_width(CREDIT_DEPTH),
  localparam int OVC_NUM         = PORT_NUM * VC_NUM_PER_PORT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_en,
  input  logic [PORT_BCD_WIDTH-1:0] alloc_port_bcd,
  input  logic [VC_BCD_WIDTH-1:0]   alloc_vc_bcd,
  input  logic                      sent_en,
  input  logic                      sent_tail,
  input  logic [PORT_BCD_WIDTH-1:0] sent_port_bcd,
  input  logic [VC_BCD_WIDTH-1:0]   sent_vc_bcd,
  input  logic [OVC_NUM-1:0]        credit_in,
  input  logic [PORT_BCD_WIDTH-1:0] rd_port_bcd,
  input  logic [VC_BCD_WIDTH-1:0]   rd_vc_bcd,
  output logic                      rd_busy,
  output logic [CREDIT_WIDTH-1:0]   rd_credit,
  output logic                      rd_no_credit,
  output logic [OVC_NUM-1:0]        ovc_busy_all,
  output logic [OVC_NUM-1:0]        ovc_avail_all,
  output logic [2:0]                err_flags
);

  logic [OVC_NUM-1:0]      alloc_hit, sent_hit, rel_hit, rd_hit;
  logic [OVC_NUM-1:0]      busy_q, busy_d;
  logic [CREDIT_WIDTH-1:0] credit_q [OVC_NUM];
  logic [CREDIT_WIDTH-1:0] credit_d [OVC_NUM];
`ifdef OVC_STATUS_ERR_EN
  logic [OVC_NUM-1:0]      uflow, oflow;
`endif

  // Decoding per OVC makes out-of-range indices match nothing.
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    for (genvar v = 0; v < VC_NUM_PER_PORT; v++) begin : g_vc
      localparam int I = flat_idx(p, v, VC_NUM_PER_PORT);

      assign alloc_hit[I] = alloc_en && (alloc_port_bcd == PORT_BCD_WIDTH'(p))
                                     && (alloc_vc_bcd == VC_BCD_WIDTH'(v));
      assign sent_hit[I]  = sent_en && (sent_port_bcd == PORT_BCD_WIDTH'(p))
                                    && (sent_vc_bcd == VC_BCD_WIDTH'(v));
      assign rd_hit[I]    = (rd_port_bcd == PORT_BCD_WIDTH'(p))
                         && (rd_vc_bcd == VC_BCD_WIDTH'(v));

      ovc_credit_cnt #(
        .CREDIT_DEPTH (CREDIT_DEPTH),
        .CREDIT_WIDTH (CREDIT_WIDTH)
      ) u_credit_cnt (
        .clk          (clk),
        .reset        (reset),
        .sent_i       (sent_hit[I]),
        .ret_i        (credit_in[I]),
        .credit_o     (credit_q[I]),
        .credit_nxt_o (credit_d[I])
`ifdef OVC_STATUS_ERR_EN
        ,
        .underflow_o  (uflow[I]),
        .overflow_o   (oflow[I])
`endif
      );
    end
  end

  // Release first, then alloc: a same-cycle release+alloc leaves the OVC busy.
  assign rel_hit = sent_hit & {OVC_NUM{sent_tail}};
  assign busy_d  = (busy_q & ~rel_hit) | alloc_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  logic                    rd_busy_q, rd_busy_d;
  logic [CREDIT_WIDTH-1:0] rd_credit_q, rd_credit_d;
  logic                    rd_no_credit_q, rd_no_credit_d;

  // The read samples next-state values so rd_* show this cycle's updates.
  always_comb begin
    rd_busy_d   = |(busy_d & rd_hit);
    rd_credit_d = '0;
    for (int i = 0; i < OVC_NUM; i++) begin
      if (rd_hit[i]) begin
        rd_credit_d = credit_d[i];
      end
    end
    rd_no_credit_d = (|rd_hit) && (rd_credit_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_busy_q      <= 1'b0;
      rd_credit_q    <= '0;
      rd_no_credit_q <= 1'b0;
    end else begin
      rd_busy_q      <= rd_busy_d;
      rd_credit_q    <= rd_credit_d;
      rd_no_credit_q <= rd_no_credit_d;
    end
  end

  assign rd_busy      = rd_busy_q;
  assign rd_credit    = rd_credit_q;
  assign rd_no_credit = rd_no_credit_q;

  always_comb begin
    ovc_avail_all = '0;
    for (int i = 0; i < OVC_NUM; i++) begin
      ovc_avail_all[i] = !busy_q[i] && (credit_q[i] != '0);
    end
  end

  assign ovc_busy_all = busy_q;

`ifdef OVC_STATUS_ERR_EN
  err_t err_q, err_d;

  always_comb begin
    err_d            = err_q;
    err_d.alloc_busy = err_q.alloc_busy | (|(alloc_hit & busy_q & ~rel_hit));
    err_d.no_credit  = err_q.no_credit | (|uflow);
    err_d.credit_ovf = err_q.credit_ovf | (|oflow);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 3'b000;
`endif

endmodule
